// File: rtl/edge_arb_pkg.sv
// Shared constants, event type and round-robin index helper for the edge event arbiter.
package edge_arb_pkg;

  localparam logic POL_RISE   = 1'b1;
  localparam logic POL_FALL   = 1'b0;
  localparam int   ARM_CYCLES = 3;
  localparam int   EVT_CH_W   = 5;

  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic                pol;
  } evt_t;

  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/edge_chan_detect.sv
// One channel: two-flop synchronizer, optional debounce (EDGE_ARB_DEBOUNCE_EN), history flop
// and rise/fall pulse generation gated by the arm flag.
module edge_chan_detect #(
  parameter int DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  input  logic i_armed,
  output logic o_rise,
  output logic o_fall
);

  logic sync1, sync2, lvl, hist, hist_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= i_sig;
      sync2 <= sync1;
      hist  <= hist_d;
    end
  end

`ifdef EDGE_ARB_DEBOUNCE_EN
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lvl    <= 1'b0;
      db_cnt <= CNT_LOAD;
    end else if (!i_armed || (sync2 == lvl) || (db_cnt == '0)) begin
      lvl    <= sync2;
      db_cnt <= CNT_LOAD;
    end else begin
      db_cnt <= db_cnt - CNT_W'(1);
    end
  end

  // Before arming, follow the input directly so a level held through reset never surfaces late.
  assign hist_d = i_armed ? lvl : sync2;
`else
  assign lvl    = sync2;
  assign hist_d = lvl;
`endif

  assign o_rise = i_armed & lvl & ~hist;
  assign o_fall = i_armed & ~lvl & hist;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: per-channel edge detection, pending/overflow tracking and a round-robin
// scheduled single event port. Define EDGE_ARB_DEBOUNCE_EN for per-channel debounce.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int DB_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_sig,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic              i_evt_ready,
  output logic              o_evt_valid,
  output logic [CH_W-1:0]   o_evt_ch,
  output logic              o_evt_pol,
  output logic [NUM_CH-1:0] o_ovf,
  input  logic [NUM_CH-1:0] i_ovf_clr
);

  logic [1:0]        arm_cnt;
  logic              armed;
  logic [NUM_CH-1:0] rise, fall, pend_rise, pend_fall;
  logic [NUM_CH-1:0] cand, cand_rot, rise_rot, take_rise, take_fall, ovf_set;
  logic [CH_W-1:0]   ptr;
  logic              load, win_found, win_rise;
  int                win_off, win_idx;
  evt_t              evt_q;

  assign armed = (arm_cnt == 2'(ARM_CYCLES));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_chan_detect #(.DB_CYCLES(DB_CYCLES)) u_det (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sig  (i_sig[g]),
      .i_armed(armed),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

  // Rotate so bit 0 is the channel under the pointer; the lowest set bit then wins.
  assign cand     = (pend_rise | pend_fall) & i_ch_en;
  assign cand_rot = NUM_CH'({cand, cand} >> ptr);
  assign rise_rot = NUM_CH'({pend_rise, pend_rise} >> ptr);

  always_comb begin
    win_found = 1'b0;
    win_off   = 0;
    win_rise  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!win_found && cand_rot[i]) begin
        win_found = 1'b1;
        win_off   = i;
        win_rise  = rise_rot[i];
      end
    end
  end

  assign win_idx = rr_index(int'(ptr), win_off, NUM_CH);
  assign load    = ~o_evt_valid | i_evt_ready;

  always_comb begin
    take_rise = '0;
    take_fall = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      take_rise[i] = load & win_found &  win_rise & (win_idx == i);
      take_fall[i] = load & win_found & ~win_rise & (win_idx == i);
    end
  end

  // A bit being handed to the output this cycle is free again, so a fresh edge there is not lost.
  assign ovf_set = i_ch_en & ((rise & pend_rise & ~take_rise) | (fall & pend_fall & ~take_fall));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      arm_cnt     <= '0;
      pend_rise   <= '0;
      pend_fall   <= '0;
      o_ovf       <= '0;
      ptr         <= '0;
      evt_q       <= '0;
      o_evt_valid <= 1'b0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      pend_rise <= ((pend_rise & ~take_rise) | rise) & i_ch_en;
      pend_fall <= ((pend_fall & ~take_fall) | fall) & i_ch_en;
      o_ovf     <= (o_ovf & ~i_ovf_clr) | ovf_set;
      if (load) begin
        o_evt_valid <= win_found;
        if (win_found) begin
          evt_q.ch  <= EVT_CH_W'(win_idx);
          evt_q.pol <= win_rise ? POL_RISE : POL_FALL;
          ptr       <= CH_W'(rr_index(win_idx, 1, NUM_CH));
        end
      end
    end
  end

  assign o_evt_ch  = CH_W'(evt_q.ch);
  assign o_evt_pol = evt_q.pol;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios plus a randomized run
// against a timeline-based reference model.
`timescale 1ns/1ps
module tb_edge_event_arbiter;

  localparam int NUM_CH    = 8;
  localparam int CH_W      = $clog2(NUM_CH);
  localparam int DB_CYCLES = 4;
`ifdef EDGE_ARB_DEBOUNCE_EN
  localparam int LAT = 4 + DB_CYCLES;
`else
  localparam int LAT = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] sig, en, clr, ovf;
  logic              ready, valid, pol;
  logic [CH_W-1:0]   ch;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DB_CYCLES(DB_CYCLES)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sig      (sig),
    .i_ch_en    (en),
    .i_evt_ready(ready),
    .o_evt_valid(valid),
    .o_evt_ch   (ch),
    .o_evt_pol  (pol),
    .o_ovf      (ovf),
    .i_ovf_clr  (clr)
  );

  // Reference model: the sampled input timeline gives edges three samples late; events
  // are sets of pending flags served round-robin from a pointer.
  logic [NUM_CH-1:0] m_h0, m_h1, m_h2, m_ovf;
  bit                m_pr[NUM_CH];
  bit                m_pf[NUM_CH];
  int                m_n, m_ch, m_ptr;
  bit                m_valid, m_pol;

  task automatic model_step();
    logic [NUM_CH-1:0] er, ef;
    int k, idx;
    if (rst) begin
      m_h0 = '0; m_h1 = '0; m_h2 = '0; m_ovf = '0;
      m_n = 0; m_ch = 0; m_ptr = 0; m_valid = 0; m_pol = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_pr[c] = 0; m_pf[c] = 0; end
    end else begin
      er = (m_n >= 3) ? (m_h1 & ~m_h2) : '0;
      ef = (m_n >= 3) ? (~m_h1 & m_h2) : '0;
      if (!m_valid || ready) begin
        k = -1;
        for (int j = 0; j < NUM_CH; j++) begin
          idx = (m_ptr + j) % NUM_CH;
          if (k < 0 && en[idx] && (m_pr[idx] || m_pf[idx])) k = idx;
        end
        if (k >= 0) begin
          m_valid = 1; m_ch = k;
          if (m_pr[k]) begin m_pol = 1; m_pr[k] = 0; end
          else begin m_pol = 0; m_pf[k] = 0; end
          m_ptr = (k + 1) % NUM_CH;
        end else begin
          m_valid = 0;
        end
      end
      m_ovf = m_ovf & ~clr;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!en[c]) begin
          m_pr[c] = 0; m_pf[c] = 0;
        end else begin
          if (er[c]) begin if (m_pr[c]) m_ovf[c] = 1'b1; m_pr[c] = 1; end
          if (ef[c]) begin if (m_pf[c]) m_ovf[c] = 1'b1; m_pf[c] = 1; end
        end
      end
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = sig;
      if (m_n < 3) m_n++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct { int c; int p; } ev_s;
  ev_s got[$];

  task automatic collect(input int n);
    got.delete();
    repeat (n) begin
      if (valid === 1'b1 && ready === 1'b1) got.push_back('{int'(ch), int'(pol)});
      tick();
    end
  endtask

  task automatic test_reset();
    int bad;
    sig = '1; en = '1; clr = '0; ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (valid !== 1'b0 || ch !== '0 || pol !== 1'b0 || ovf !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ch=%0d pol=%b ovf=%h, want 0/0/0/00", valid, ch, pol, ovf);
    end
    rst = 1'b0;
    bad = 0;
    repeat (20) begin tick(); if (valid !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL high_at_reset: %0d cycles with valid, want 0", bad);
    end
    sig[3] = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL early_valid: cycle %0d valid=%b, want 0", i, valid);
      end
    end
    tick();
    checks++;
    if (valid !== 1'b1 || ch !== 3'd3 || pol !== 1'b0) begin
      errors++;
      $display("FAIL ch3_fall: valid=%b ch=%0d pol=%b, want 1/3/0", valid, ch, pol);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_event: valid=%b, want 0", valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_a[3] = '{0, 5, 7};
    int exp_c[3] = '{2, 6, 0};
    int exp_p[3] = '{1, 1, 0};
    sig = '0; en = '1; ready = 1'b1;
    do_reset();
    repeat (5) tick();
    sig = 8'b1010_0001;
    repeat (LAT - 1) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || int'(ch) != exp_a[i] || pol !== 1'b1) begin
        errors++;
        $display("FAIL rr_order[%0d]: valid=%b ch=%0d pol=%b, want 1/%0d/1", i, valid, ch, pol, exp_a[i]);
      end
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: valid=%b, want 0", valid);
    end
    ready = 1'b0;
    sig[2] = 1'b1;
    repeat (LAT) tick();
    sig[0] = 1'b0; sig[6] = 1'b1;
    repeat (LAT) tick();
    ready = 1'b1;
    collect(10);
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL rr_fair_count: got %0d events, want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i].c != exp_c[i] || got[i].p != exp_p[i]) begin
        errors++;
        $display("FAIL rr_fair[%0d]: ch=%0d pol=%0d, want ch=%0d pol=%0d", i, got[i].c, got[i].p, exp_c[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_hold_ovf();
    int exp_p[3] = '{1, 1, 0};
    bit stable;
    sig = '0; en = '1; ready = 1'b1;
    do_reset();
    repeat (5) tick();
    ready = 1'b0;
    sig[2] = 1'b1;
    repeat (LAT) tick();
    checks++;
    if (valid !== 1'b1 || ch !== 3'd2 || pol !== 1'b1) begin
      errors++;
      $display("FAIL hold_first: valid=%b ch=%0d pol=%b, want 1/2/1", valid, ch, pol);
    end
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 2 || c == 8) sig[2] = 1'b0;
      if (c == 5 || c == 11) sig[2] = 1'b1;
      tick();
      if (valid !== 1'b1 || ch !== 3'd2 || pol !== 1'b1) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable: output changed while stalled (now ch=%0d pol=%b)", ch, pol);
    end
    checks++;
    if (ovf !== 8'h04) begin
      errors++;
      $display("FAIL ovf_set: ovf=%h, want 04", ovf);
    end
    ready = 1'b1;
    collect(10);
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL hold_release_count: got %0d events, want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i].c != 2 || got[i].p != exp_p[i]) begin
        errors++;
        $display("FAIL hold_release[%0d]: ch=%0d pol=%0d, want ch=2 pol=%0d", i, got[i].c, got[i].p, exp_p[i]);
      end
    end
  endtask

  task automatic test_ovf_clr();
    ready = 1'b0;
    sig[2] = 1'b0; repeat (4) tick();
    sig[2] = 1'b1; repeat (4) tick();
    sig[2] = 1'b0; repeat (4) tick();
    sig[2] = 1'b1;
    tick(); tick();
    clr[2] = 1'b1;
    tick();
    clr = '0;
    checks++;
    if (ovf[2] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf[2]=%b, want 1", ovf[2]);
    end
    tick();
    clr[2] = 1'b1;
    tick();
    clr = '0;
    checks++;
    if (ovf !== 8'h00) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%h, want 00", ovf);
    end
    ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_disable();
    sig = '0; en = '1; ready = 1'b0;
    do_reset();
    repeat (5) tick();
    sig[1] = 1'b1; repeat (LAT) tick();
    sig[4] = 1'b1; repeat (LAT) tick();
    en[4] = 1'b0; tick();
    sig[4] = 1'b0; repeat (3) tick();
    sig[4] = 1'b1; repeat (3) tick();
    sig[4] = 1'b0; repeat (4) tick();
    ready = 1'b1;
    collect(10);
    checks++;
    if (got.size() != 1 || got[0].c != 1 || got[0].p != 1) begin
      errors++;
      $display("FAIL disable_drop: %0d events (first ch=%0d), want only ch=1 rise",
               got.size(), (got.size() > 0) ? got[0].c : -1);
    end
    en[4] = 1'b1; tick();
    sig[4] = 1'b1;
    collect(10);
    checks++;
    if (got.size() != 1 || got[0].c != 4 || got[0].p != 1) begin
      errors++;
      $display("FAIL reenable: %0d events (first ch=%0d), want only ch=4 rise",
               got.size(), (got.size() > 0) ? got[0].c : -1);
    end
  endtask

  task automatic test_random();
    int r, bad;
    sig = '0; en = '1; clr = '0; ready = 1'b1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin r = $urandom_range(0, NUM_CH - 1); sig[r] = ~sig[r]; end
      if ($urandom_range(0, 15) == 0) begin r = $urandom_range(0, NUM_CH - 1); en[r] = ~en[r]; end
      ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      tick();
      checks++;
      if (valid !== m_valid || (m_valid && (int'(ch) != m_ch || pol !== m_pol)) || ovf !== m_ovf) begin
        errors++;
        $display("FAIL random[%0d]: valid=%b ch=%0d pol=%b ovf=%h, want valid=%b ch=%0d pol=%b ovf=%h",
                 c, valid, ch, pol, ovf, m_valid, m_ch, m_pol, m_ovf);
      end
    end
    en = '1; clr = '0; ready = 1'b0;
    sig = ~sig;
    repeat (6) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (valid !== 1'b0 || ovf !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ovf=%h, want 0/00", valid, ovf);
    end
    ready = 1'b1;
    bad = 0;
    repeat (12) begin tick(); if (valid !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_discard: %0d cycles with valid, want 0", bad);
    end
  endtask

  task automatic test_debounce();
    int bad;
    bit found;
    sig = '0; en = '1; ready = 1'b1;
    do_reset();
    repeat (10) tick();
    sig[1] = 1'b1; repeat (3) tick(); sig[1] = 1'b0;
    bad = 0;
    repeat (20) begin tick(); if (valid !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL db_short_pulse: %0d cycles with valid, want 0", bad);
    end
    sig[1] = 1'b1;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      if (t == 5) sig[1] = 1'b0;
      checks++;
      if (t < LAT && valid !== 1'b0) begin
        errors++;
        $display("FAIL db_early: t=%0d valid=%b, want 0", t, valid);
      end
      if (t == LAT && (valid !== 1'b1 || ch !== 3'd1 || pol !== 1'b1)) begin
        errors++;
        $display("FAIL db_rise: valid=%b ch=%0d pol=%b, want 1/1/1", valid, ch, pol);
      end
    end
    found = 0;
    repeat (20) begin
      tick();
      if (valid === 1'b1 && ch === 3'd1 && pol === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL db_fall: no ch=1 fall event seen, want one");
    end
  endtask

  initial begin
    rst = 1'b1; sig = '0; en = '1; clr = '0; ready = 1'b1;
    test_reset();
`ifdef EDGE_ARB_DEBOUNCE_EN
    test_debounce();
`else
    test_round_robin();
    test_hold_ovf();
    test_ovf_clr();
    test_disable();
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
